// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared raster timing definitions for the graphic controller.
//   - 640x480@60 timing constants (used as defaults by vga_timing_gen)
//   - calc_h_total / calc_v_total: total line/frame lengths from the parts
//   - cnt_width: register width needed to count 0..n-1 (minimum 1 bit)
//   - COORD_W: width of the x/y coordinate buses seen by overlay stages
//   - sync_bits_t / SYNC_IDLE: the sync/blank bundle and its inactive value
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int COORD_W = 32;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    function automatic int calc_h_total(input int active, input int fp,
                                        input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int calc_v_total(input int active, input int fp,
                                        input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Sync bundle carried through the alignment pipeline (syncs active-low).
    typedef struct packed {
        logic hs_n;
        logic vs_n;
        logic active;
    } sync_bits_t;

    localparam int         SYNC_W    = $bits(sync_bits_t);
    localparam sync_bits_t SYNC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, active: 1'b0};

endpackage

// File: rtl/vga_timing_gen_sync_delay.sv
// ---------------------------------------------------------------------------
// vga_sync_delay
// LAT-deep shift register with enable. Used to delay the sync/blank bundle
// by a number of pixel ticks so it lines up with RGB data coming back from
// synchronous ROMs. LAT=0 is a plain wire.
// Ports:
//   clk      - system clock
//   i_rst_n  - asynchronous active-low reset, loads every stage with RST_VAL
//   i_en     - shift enable (one pixel tick)
//   i_d      - W-bit input
//   o_q      - W-bit output, i_d delayed LAT enabled cycles
// ---------------------------------------------------------------------------
module vga_sync_delay #(
    parameter int             W       = 3,
    parameter int             LAT     = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    generate
        if (LAT == 0) begin : g_bypass
            assign o_q = i_d;
        end else begin : g_pipe
            logic [W-1:0] r_pipe [LAT];

            always_ff @(posedge clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int i = 0; i < LAT; i++) begin
                        r_pipe[i] <= RST_VAL;
                    end
                end else if (i_en) begin
                    r_pipe[0] <= i_d;
                    for (int i = 1; i < LAT; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign o_q = r_pipe[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Free-running VGA raster timing generator.
// Ports:
//   clk            - system clock
//   rst_n_i        - asynchronous active-low reset
//   pix_en_o       - one-clk pixel tick, every CLK_DIV clocks (always 1 if CLK_DIV=1)
//   x_pos_o        - horizontal counter, zero-extended, direct from register
//   y_pos_o        - vertical counter, zero-extended, direct from register
//   active_o       - undelayed visible-area flag
//   hsync_o        - active-low hsync, delayed PIPE_LAT ticks
//   vsync_o        - active-low vsync, delayed PIPE_LAT ticks
//   blank_n_o      - delayed active_o (1 = drive RGB)
//   vga_clk_o      - registered pixel clock for the DAC
//   frame_start_o  - pulse on the tick where the counters sit at (0,0)
//   line_start_o   - pulse on the tick where x=0
// ---------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int CLK_DIV  = 2,
    parameter int PIPE_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n_i,
    output logic               pix_en_o,
    output logic [COORD_W-1:0] x_pos_o,
    output logic [COORD_W-1:0] y_pos_o,
    output logic               active_o,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               blank_n_o,
    output logic               vga_clk_o,
    output logic               frame_start_o,
    output logic               line_start_o
);

    localparam int H_TOTAL  = calc_h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL  = calc_v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int H_W      = cnt_width(H_TOTAL);
    localparam int V_W      = cnt_width(V_TOTAL);
    localparam int DIV_W    = cnt_width(CLK_DIV);
    localparam int DIV_HALF = CLK_DIV / 2;

    localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [H_W-1:0]   H_VIS    = H_W'(H_ACTIVE);
    localparam logic [V_W-1:0]   V_VIS    = V_W'(V_ACTIVE);
    localparam logic [H_W-1:0]   HS_FIRST = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0]   HS_LAST  = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [V_W-1:0]   VS_FIRST = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0]   VS_LAST  = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic [DIV_W-1:0] w_div_next;
    logic             r_pix_en;
    logic             r_vga_clk;
    logic [H_W-1:0]   r_h_cnt;
    logic [V_W-1:0]   r_v_cnt;
    sync_bits_t       w_raw;
    sync_bits_t       w_dly;

    // ---------------------------------------------------------------------
    // Clock divider. pix_en is registered from the terminal count so the
    // first tick lands CLK_DIV clocks after reset release.
    // ---------------------------------------------------------------------
    assign w_div_next = (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DIV_W'(1);

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_div_cnt <= '0;
            r_pix_en  <= 1'b0;
            r_vga_clk <= 1'b0;
        end else begin
            r_div_cnt <= w_div_next;
            r_pix_en  <= (r_div_cnt == DIV_LAST);
            // Tracks the divider value being loaded, so vga_clk is high
            // exactly while div_cnt sits in its upper half.
            r_vga_clk <= (int'(w_div_next) >= DIV_HALF);
        end
    end

    // ---------------------------------------------------------------------
    // Raster counters, advancing once per pixel tick.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_pix_en) begin
            if (r_h_cnt == H_LAST) begin
                r_h_cnt <= '0;
                if (r_v_cnt == V_LAST) begin
                    r_v_cnt <= '0;
                end else begin
                    r_v_cnt <= r_v_cnt + V_W'(1);
                end
            end else begin
                r_h_cnt <= r_h_cnt + H_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Raw decodes and alignment delay
    // ---------------------------------------------------------------------
    assign w_raw.hs_n   = !((r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST));
    assign w_raw.vs_n   = !((r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST));
    assign w_raw.active = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);

    vga_sync_delay #(
        .W       (SYNC_W),
        .LAT     (PIPE_LAT),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_delay (
        .clk     (clk),
        .i_rst_n (rst_n_i),
        .i_en    (r_pix_en),
        .i_d     (w_raw),
        .o_q     (w_dly)
    );

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign pix_en_o      = r_pix_en;
    assign vga_clk_o     = r_vga_clk;
    assign x_pos_o       = COORD_W'(r_h_cnt);
    assign y_pos_o       = COORD_W'(r_v_cnt);
    assign active_o      = w_raw.active;
    assign hsync_o       = w_dly.hs_n;
    assign vsync_o       = w_dly.vs_n;
    assign blank_n_o     = w_dly.active;
    assign line_start_o  = r_pix_en && (r_h_cnt == '0);
    assign frame_start_o = r_pix_en && (r_h_cnt == '0) && (r_v_cnt == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Three instances share clock and reset:
//   d - default 640x480 timing, CLK_DIV=2, PIPE_LAT=1
//   s - shrunken raster (35x21), CLK_DIV=2, PIPE_LAT=1, for whole-frame checks
//   c - default timing, CLK_DIV=1, PIPE_LAT=0
// The expected output vector for each clock is computed from k, the number
// of clock edges since reset release, by a closed-form timing model.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int OBS_W = 72;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   k = 0;
    int   total = 0;
    int   bad = 0;

    logic [OBS_W-1:0] exp_q[$];

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    // ---------------- DUTs ----------------
    logic [31:0] x_d, y_d, x_s, y_s, x_c, y_c;
    logic pix_d, act_d, hs_d, vs_d, bn_d, vclk_d, fs_d, ls_d;
    logic pix_s, act_s, hs_s, vs_s, bn_s, vclk_s, fs_s, ls_s;
    logic pix_c, act_c, hs_c, vs_c, bn_c, vclk_c, fs_c, ls_c;
    logic [OBS_W-1:0] obs_d, obs_s, obs_c;

    assign obs_d = {x_d, y_d, pix_d, vclk_d, ls_d, fs_d, act_d, hs_d, vs_d, bn_d};
    assign obs_s = {x_s, y_s, pix_s, vclk_s, ls_s, fs_s, act_s, hs_s, vs_s, bn_s};
    assign obs_c = {x_c, y_c, pix_c, vclk_c, ls_c, fs_c, act_c, hs_c, vs_c, bn_c};

    vga_timing_gen dut_d (
        .clk(clk), .rst_n_i(rst_n), .pix_en_o(pix_d), .x_pos_o(x_d), .y_pos_o(y_d),
        .active_o(act_d), .hsync_o(hs_d), .vsync_o(vs_d), .blank_n_o(bn_d),
        .vga_clk_o(vclk_d), .frame_start_o(fs_d), .line_start_o(ls_d)
    );

    vga_timing_gen #(
        .H_ACTIVE(20), .H_FP(4), .H_SYNC(6), .H_BP(5),
        .V_ACTIVE(12), .V_FP(3), .V_SYNC(2), .V_BP(4),
        .CLK_DIV(2), .PIPE_LAT(1)
    ) dut_s (
        .clk(clk), .rst_n_i(rst_n), .pix_en_o(pix_s), .x_pos_o(x_s), .y_pos_o(y_s),
        .active_o(act_s), .hsync_o(hs_s), .vsync_o(vs_s), .blank_n_o(bn_s),
        .vga_clk_o(vclk_s), .frame_start_o(fs_s), .line_start_o(ls_s)
    );

    vga_timing_gen #(.CLK_DIV(1), .PIPE_LAT(0)) dut_c (
        .clk(clk), .rst_n_i(rst_n), .pix_en_o(pix_c), .x_pos_o(x_c), .y_pos_o(y_c),
        .active_o(act_c), .hsync_o(hs_c), .vsync_o(vs_c), .blank_n_o(bn_c),
        .vga_clk_o(vclk_c), .frame_start_o(fs_c), .line_start_o(ls_c)
    );

    // ---------------- timing model ----------------
    // After k edges (k=0 means in/just out of reset) the divider has produced
    // ticks after edges d, 2d, ...; the counters have consumed floor((k-1)/d)
    // of them. The delayed bundle shows the raster position lat ticks back.
    function automatic logic [OBS_W-1:0] model(input int kk, input int d, input int lat,
                                               input int ha, input int hf, input int hw,
                                               input int hb, input int va, input int vf,
                                               input int vw, input int vb);
        int ht, vt, p, pd, x, y, xd, yd;
        logic pix, vclk, ls, fs, act, hs, vs, bn;
        ht   = ha + hf + hw + hb;
        vt   = va + vf + vw + vb;
        p    = (kk >= 1) ? (kk - 1) / d : 0;
        x    = p % ht;
        y    = (p / ht) % vt;
        pix  = (kk >= 1) && (kk % d == 0);
        vclk = (kk >= 1) && ((kk % d) >= d / 2);
        ls   = pix && (x == 0);
        fs   = ls && (y == 0);
        act  = (x < ha) && (y < va);
        if (p >= lat) begin
            pd = p - lat;
            xd = pd % ht;
            yd = (pd / ht) % vt;
            hs = !((xd >= ha + hf) && (xd < ha + hf + hw));
            vs = !((yd >= va + vf) && (yd < va + vf + vw));
            bn = (xd < ha) && (yd < va);
        end else begin
            hs = 1'b1;
            vs = 1'b1;
            bn = 1'b0;
        end
        return {32'(x), 32'(y), pix, vclk, ls, fs, act, hs, vs, bn};
    endfunction

    function automatic logic [OBS_W-1:0] model_d(input int kk);
        return model(kk, 2, 1, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic logic [OBS_W-1:0] model_s(input int kk);
        return model(kk, 2, 1, 20, 4, 6, 5, 12, 3, 2, 4);
    endfunction

    function automatic logic [OBS_W-1:0] model_c(input int kk);
        return model(kk, 1, 0, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        logic [OBS_W-1:0] e;
        repeat (3) @(negedge clk);
        e = model_d(0);
        total++;
        if (obs_d !== e) begin
            bad++;
            $display("FAIL reset_d got=%h exp=%h", obs_d, e);
        end
        e = model_s(0);
        total++;
        if (obs_s !== e) begin
            bad++;
            $display("FAIL reset_s got=%h exp=%h", obs_s, e);
        end
    endtask

    task automatic test_line();
        logic [OBS_W-1:0] e;
        int first_pix = -1;
        int ls_cnt = 0;
        for (int i = 0; i < 3300; i++) begin
            exp_q.push_back(model_d(k + 1));
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (obs_d !== e) begin
                bad++;
                $display("FAIL line_d k=%0d got=%h exp=%h", k, obs_d, e);
            end
            if (pix_d === 1'b1 && first_pix < 0) first_pix = k;
            if (i >= 100 && i < 1700 && ls_d === 1'b1) ls_cnt++;
        end
        total++;
        if (first_pix !== 2) begin
            bad++;
            $display("FAIL first_tick got=%0d exp=2", first_pix);
        end
        total++;
        if (ls_cnt !== 1) begin
            bad++;
            $display("FAIL line_start_per_1600 got=%0d exp=1", ls_cnt);
        end
    endtask

    task automatic test_hsync();
        logic [OBS_W-1:0] e;
        int low_clks = 0;
        int first_x = -1;
        int last_x = -1;
        for (int i = 0; i < 1600; i++) begin
            exp_q.push_back(model_d(k + 1));
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (obs_d !== e) begin
                bad++;
                $display("FAIL hsync_d k=%0d got=%h exp=%h", k, obs_d, e);
            end
            if (hs_d === 1'b0) begin
                low_clks++;
                if (first_x < 0) first_x = int'(x_d);
                last_x = int'(x_d);
            end
        end
        total++;
        if (low_clks !== 192) begin
            bad++;
            $display("FAIL hsync_low_clks got=%0d exp=192", low_clks);
        end
        total++;
        if (first_x !== 657) begin
            bad++;
            $display("FAIL hsync_first_x got=%0d exp=657", first_x);
        end
        total++;
        if (last_x !== 752) begin
            bad++;
            $display("FAIL hsync_last_x got=%0d exp=752", last_x);
        end
    endtask

    task automatic test_vsync_blank();
        logic [OBS_W-1:0] e;
        int vs_low = 0;
        int bn_low = 0;
        int fs_cnt = 0;
        for (int i = 0; i < 1470; i++) begin
            exp_q.push_back(model_s(k + 1));
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (obs_s !== e) begin
                bad++;
                $display("FAIL frame_s k=%0d got=%h exp=%h", k, obs_s, e);
            end
            if (vs_s === 1'b0) vs_low++;
            if (bn_s === 1'b0) bn_low++;
            if (fs_s === 1'b1) fs_cnt++;
        end
        total++;
        if (vs_low !== 140) begin
            bad++;
            $display("FAIL vsync_low_clks got=%0d exp=140", vs_low);
        end
        total++;
        if (bn_low !== 990) begin
            bad++;
            $display("FAIL blank_low_clks got=%0d exp=990", bn_low);
        end
        total++;
        if (fs_cnt !== 1) begin
            bad++;
            $display("FAIL frame_start_per_frame got=%0d exp=1", fs_cnt);
        end
    endtask

    task automatic test_corner();
        logic [OBS_W-1:0] e;
        int pix_cnt = 0;
        int ls_cnt = 0;
        for (int i = 0; i < 1700; i++) begin
            exp_q.push_back(model_c(k + 1));
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (obs_c !== e) begin
                bad++;
                $display("FAIL corner_c k=%0d got=%h exp=%h", k, obs_c, e);
            end
            if (pix_c === 1'b1) pix_cnt++;
            if (i < 800 && ls_c === 1'b1) ls_cnt++;
        end
        total++;
        if (pix_cnt !== 1700) begin
            bad++;
            $display("FAIL corner_pix_cnt got=%0d exp=1700", pix_cnt);
        end
        total++;
        if (ls_cnt !== 1) begin
            bad++;
            $display("FAIL corner_line_per_800 got=%0d exp=1", ls_cnt);
        end
    endtask

    task automatic test_midline_reset();
        logic [OBS_W-1:0] e;
        int first_pix = -1;
        // Restart from a clean reset so the position is known.
        @(negedge clk);
        rst_n = 1'b0;
        release_reset();
        for (int i = 0; i < 2201; i++) begin
            exp_q.push_back(model_d(k + 1));
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (obs_d !== e) begin
                bad++;
                $display("FAIL prerst_d k=%0d got=%h exp=%h", k, obs_d, e);
            end
        end
        total++;
        if (x_d !== 32'd300 || y_d !== 32'd1) begin
            bad++;
            $display("FAIL prerst_pos got=%0d,%0d exp=300,1", x_d, y_d);
        end
        // Assert between edges and look before the next posedge.
        #2;
        rst_n = 1'b0;
        #1;
        e = model_d(0);
        total++;
        if (obs_d !== e) begin
            bad++;
            $display("FAIL async_rst got=%h exp=%h", obs_d, e);
        end
        repeat (3) @(negedge clk);
        total++;
        if (obs_d !== e) begin
            bad++;
            $display("FAIL rst_hold got=%h exp=%h", obs_d, e);
        end
        release_reset();
        for (int i = 0; i < 40; i++) begin
            exp_q.push_back(model_d(k + 1));
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (obs_d !== e) begin
                bad++;
                $display("FAIL postrst_d k=%0d got=%h exp=%h", k, obs_d, e);
            end
            if (pix_d === 1'b1 && first_pix < 0) first_pix = k;
        end
        total++;
        if (first_pix !== 2) begin
            bad++;
            $display("FAIL postrst_first_tick got=%0d exp=2", first_pix);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        release_reset();
        test_line();
        test_hsync();
        test_vsync_blank();
        test_corner();
        test_midline_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
